// File: rtl/su_fwd_ctl.sv
// Scalar-unit operand-forwarding and load-use hazard controller.
// Tracks the destination writes of EX/DF/WB and steers the RD-stage operand muxes.
module su_fwd_ctl #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          pipe_hold,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_rs,
  input  logic [AW-1:0] rd_rt,
  input  logic          rd_use_rs,
  input  logic          rd_use_rt,
  input  logic          rd_use_imm,
  input  logic [AW-1:0] rd_dest,
  input  logic          rd_wr,
  input  logic          rd_load,
  output logic [4:0]    surdamux,
  output logic [5:0]    surdbmux,
  output logic          load_stall,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr
);

  typedef struct packed {
    logic          v;
    logic          ld;
    logic [AW-1:0] dest;
  } stage_t;

  stage_t ex_q, df_q, wb_q;
  stage_t ex_d;

  // A stage hit on $0 is never a hazard: $0 reads as zero regardless of producers.
  function automatic logic hit(input stage_t s, input logic [AW-1:0] r);
    return s.v && (s.dest == r) && (r != '0);
  endfunction

  function automatic logic ldhaz(input logic [AW-1:0] r);
    return (hit(ex_q, r) && ex_q.ld) || (hit(df_q, r) && df_q.ld);
  endfunction

  always_comb begin
    load_stall = rd_valid &&
                 ((rd_use_rs && ldhaz(rd_rs)) ||
                  (rd_use_rt && !rd_use_imm && ldhaz(rd_rt)));
  end

  // Youngest producer wins, so EX is tested before DF before WB.
  always_comb begin
    // NOTE: default assigned first so every path drives the select and no latch is inferred.
    surdamux = 5'b00001;
    if (!reset_l)                surdamux = 5'b00001;
    else if (rd_rs == '0)        surdamux = 5'b10000;
    else if (hit(ex_q, rd_rs))   surdamux = 5'b00010;
    else if (hit(df_q, rd_rs))   surdamux = 5'b00100;
    else if (hit(wb_q, rd_rs))   surdamux = 5'b01000;
  end

  always_comb begin
    surdbmux = 6'b000001;
    if (!reset_l)                surdbmux = 6'b000001;
    else if (rd_use_imm)         surdbmux = 6'b010000;
    else if (rd_rt == '0)        surdbmux = 6'b100000;
    else if (hit(ex_q, rd_rt))   surdbmux = 6'b000010;
    else if (hit(df_q, rd_rt))   surdbmux = 6'b000100;
    else if (hit(wb_q, rd_rt))   surdbmux = 6'b001000;
  end

  // A stalled RD injects a bubble into EX; writes to $0 are never tracked.
  always_comb begin
    ex_d.v    = rd_valid && rd_wr && (rd_dest != '0) && !load_stall;
    ex_d.ld   = ex_d.v && rd_load;
    ex_d.dest = rd_dest;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ex_q <= '0;
      df_q <= '0;
      wb_q <= '0;
    end else if (!pipe_hold) begin
      // NOTE: non-blocking so each stage samples its neighbour's pre-edge value.
      wb_q <= df_q;
      df_q <= ex_q;
      ex_q <= ex_d;
    end
  end

  assign wb_we   = wb_q.v && !pipe_hold;
  assign wb_addr = wb_q.dest;

endmodule

// File: tb/tb_su_fwd_ctl.sv
// Bench for su_fwd_ctl: a stage-array model checked every negedge, plus
// directed scenarios with literal expectations.
module tb_su_fwd_ctl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          pipe_hold = 1'b0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_rs = '0, rd_rt = '0, rd_dest = '0;
  logic          rd_use_rs = 1'b0, rd_use_rt = 1'b0, rd_use_imm = 1'b0;
  logic          rd_wr = 1'b0, rd_load = 1'b0;
  logic [4:0]    surdamux;
  logic [5:0]    surdbmux;
  logic          load_stall, wb_we;
  logic [AW-1:0] wb_addr;

  int errors = 0;
  int checks = 0;

  su_fwd_ctl #(.AW(AW)) dut (
    .clk(clk), .reset_l(reset_l), .pipe_hold(pipe_hold), .rd_valid(rd_valid),
    .rd_rs(rd_rs), .rd_rt(rd_rt), .rd_use_rs(rd_use_rs), .rd_use_rt(rd_use_rt),
    .rd_use_imm(rd_use_imm), .rd_dest(rd_dest), .rd_wr(rd_wr), .rd_load(rd_load),
    .surdamux(surdamux), .surdbmux(surdbmux), .load_stall(load_stall),
    .wb_we(wb_we), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: index 0 = EX, 1 = DF, 2 = WB.
  logic          m_v[3];
  logic          m_ld[3];
  logic [AW-1:0] m_dest[3];

  function automatic int youngest(input logic [AW-1:0] r);
    for (int s = 0; s < 3; s++)
      if (m_v[s] && m_dest[s] == r) return s;
    return -1;
  endfunction

  function automatic logic load_pending(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (m_v[s] && m_ld[s] && m_dest[s] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return rd_valid && ((rd_use_rs && load_pending(rd_rs)) ||
                        (rd_use_rt && !rd_use_imm && load_pending(rd_rt)));
  endfunction

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int s = 0; s < 3; s++) begin
        m_v[s] <= 1'b0; m_ld[s] <= 1'b0; m_dest[s] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int s = 1; s < 3; s++) begin
        m_v[s] <= m_v[s-1]; m_ld[s] <= m_ld[s-1]; m_dest[s] <= m_dest[s-1];
      end
      m_v[0]    <= !m_stall() && rd_valid && rd_wr && rd_dest != 0;
      m_ld[0]   <= !m_stall() && rd_valid && rd_wr && rd_dest != 0 && rd_load;
      m_dest[0] <= rd_dest;
    end
  end

  always @(negedge clk) begin
    logic [4:0] ea;
    logic [5:0] eb;
    int sa, sb;
    sa = youngest(rd_rs);
    sb = youngest(rd_rt);
    if (!reset_l)        ea = 5'b00001;
    else if (rd_rs == 0) ea = 5'b10000;
    else if (sa >= 0)    ea = 5'(1 << (sa + 1));
    else                 ea = 5'b00001;
    if (!reset_l)        eb = 6'b000001;
    else if (rd_use_imm) eb = 6'b010000;
    else if (rd_rt == 0) eb = 6'b100000;
    else if (sb >= 0)    eb = 6'(1 << (sb + 1));
    else                 eb = 6'b000001;
    check("model surdamux", 32'(surdamux), 32'(ea));
    check("model surdbmux", 32'(surdbmux), 32'(eb));
    check("model load_stall", 32'(load_stall), 32'(m_stall()));
    check("model wb_we", 32'(wb_we), 32'(m_v[2] && !pipe_hold));
    if (m_v[2]) check("model wb_addr", 32'(wb_addr), 32'(m_dest[2]));
  end

  task automatic set_rd(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic imm,
                        input logic [AW-1:0] dest, input logic wr, input logic ld);
    rd_valid = v; rd_rs = rs; rd_rt = rt; rd_use_rs = urs; rd_use_rt = urt;
    rd_use_imm = imm; rd_dest = dest; rd_wr = wr; rd_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset with arbitrary inputs, including $0 sources.
    set_rd(1, 0, 0, 1, 1, 0, 6, 1, 1);
    @(negedge clk);
    check("reset amux", 32'(surdamux), 32'h01);
    check("reset bmux", 32'(surdbmux), 32'h01);
    check("reset stall", 32'(load_stall), 0);
    check("reset wb_we", 32'(wb_we), 0);
    #2 reset_l = 1'b1;
    set_rd(1, 5, 6, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("first read $5 amux", 32'(surdamux), 32'h01);

    // ALU chain on $3.
    tick();
    set_rd(1, 1, 2, 1, 1, 0, 3, 1, 0);
    tick();
    set_rd(1, 3, 3, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("alu ex amux", 32'(surdamux), 32'h02);
    check("alu ex bmux", 32'(surdbmux), 32'h02);
    tick(); @(negedge clk);
    check("alu df amux", 32'(surdamux), 32'h04);
    tick(); @(negedge clk);
    check("alu wb amux", 32'(surdamux), 32'h08);
    check("alu wb bmux", 32'(surdbmux), 32'h08);
    tick(); @(negedge clk);
    check("alu retired amux", 32'(surdamux), 32'h01);

    // Load-use on $7.
    tick();
    set_rd(1, 1, 0, 1, 0, 0, 7, 1, 1);
    tick();
    set_rd(1, 7, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("ld stall 1", 32'(load_stall), 1);
    tick(); @(negedge clk);
    check("ld stall 2", 32'(load_stall), 1);
    check("ld stall 2 amux", 32'(surdamux), 32'h04);
    tick(); @(negedge clk);
    check("ld resolved stall", 32'(load_stall), 0);
    check("ld resolved amux", 32'(surdamux), 32'h08);

    // $0 handling.
    tick();
    set_rd(1, 1, 2, 1, 1, 0, 0, 1, 0);
    tick();
    set_rd(1, 0, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("zero amux", 32'(surdamux), 32'h10);
    check("zero bmux", 32'(surdbmux), 32'h20);
    check("zero stall", 32'(load_stall), 0);
    rd_use_imm = 1'b1;
    #1 check("imm bmux", 32'(surdbmux), 32'h10);

    // Priority: $4 in EX, DF and WB at once.
    tick();
    set_rd(1, 1, 2, 1, 1, 0, 4, 1, 0);
    tick(); tick(); tick();
    set_rd(1, 4, 4, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("prio ex amux", 32'(surdamux), 32'h02);
    check("prio ex bmux", 32'(surdbmux), 32'h02);
    check("prio wb_we", 32'(wb_we), 1);
    check("prio wb_addr", 32'(wb_addr), 4);
    tick(); @(negedge clk);
    check("prio df amux", 32'(surdamux), 32'h04);

    // Hold with a load in EX.
    tick();
    set_rd(1, 1, 0, 1, 0, 0, 9, 1, 1);
    tick();
    set_rd(1, 9, 0, 1, 0, 0, 0, 0, 0);
    pipe_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold stall", 32'(load_stall), 1);
      check("hold wb_we", 32'(wb_we), 0);
      check("hold amux", 32'(surdamux), 32'h02);
      tick();
    end
    pipe_hold = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!load_stall) break;
      n++;
      tick();
    end
    check("hold stall count", 32'(n), 2);

    // Reset asserted mid-stall.
    tick();
    set_rd(1, 1, 0, 1, 0, 0, 10, 1, 1);
    tick();
    set_rd(1, 10, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("pre-reset stall", 32'(load_stall), 1);
    #2 reset_l = 1'b0;
    #1;
    check("mid-reset stall", 32'(load_stall), 0);
    check("mid-reset amux", 32'(surdamux), 32'h01);
    check("mid-reset wb_we", 32'(wb_we), 0);
    #4 reset_l = 1'b1;
    @(negedge clk);
    check("post-reset stall", 32'(load_stall), 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
